load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the MEM-stage control of the MIPS core and the word-wide data memory. Accepts one load/store request at a time, keyed by the raw MIPS opcode, and checks alignment. Drives the memory's read/write strobes and sign- or zero-extends load results. Sub-word stores (sb/sh) are done as a read-modify-write, so the memory only ever sees full-word accesses.

## Interface
- ADDR_W, 32, byte-address width toward core and memory
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- req  in  1  request valid; sampled only when ready=1
- opcode  in  6  MIPS opcode: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011
- addr  in  ADDR_W  byte address of the access
- store_data  in  32  store operand; byte in [7:0], half in [15:0]
- ready  out  1  unit idle and accepting; forced 0 while rst=1
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; misaligned address or unsupported opcode
- load_data  out  32  extended load result; valid with done, else holds last value
- mem_address  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_writeData  out  32  full word to write
- mem_MemRead  out  1  read strobe; memory registers readData on this edge
- mem_MemWrite  out  1  write strobe; memory writes on this edge
- mem_readData  in  32  memory read result, valid the cycle after mem_MemRead

## Operation
- Big-endian lanes: addr[1:0]=0 selects bits [31:24]; =3 selects [7:0]. Halfword addr[1]=0 selects [31:16].
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE: ready=1. When req=1, register opcode/addr/store_data; later input changes are ignored.
  - Fault (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0; any other opcode): go to RESP with fault=1, load_data=0. No memory strobe.
  - Loads and sb/sh: go to READ.
  - sw: go to WRITE with mem_writeData=store_data.
- READ: mem_MemRead=1, then CAPTURE.
- CAPTURE: mem_readData is valid.
  - Load: register the extracted lane into load_data. lb/lh sign-extend; lbu/lhu/lw zero-extend or pass through. Then RESP.
  - sb/sh: register the merged word (selected lane replaced by store_data[7:0]/[15:0], other lanes unchanged). Then WRITE.
- WRITE: mem_MemWrite=1, mem_writeData=merged or sw word, then RESP.
- RESP: done=1 for one cycle, then IDLE.
- mem_MemRead and mem_MemWrite are never high together. Both are decoded from state and gated low by rst.
- Reset values: state=IDLE, done=0, fault=0, load_data=0, strobes=0, mem_address=0, mem_writeData=0.
- rst mid-operation abandons the access at once: no write is issued in the cycle rst is high, and no done is produced.

## Timing
- Cycle 0 is the cycle in which req=1 and ready=1.
- Loads: READ in cycle 1, CAPTURE in cycle 2, done in cycle 3. ready returns in cycle 4.
- sw: WRITE in cycle 1, done in cycle 2.
- sb/sh: READ in 1, CAPTURE in 2, WRITE in 3, done in 4.
- Fault: done=1 and fault=1 in cycle 1.
- Back-to-back: the next request is accepted in the cycle after RESP at the earliest. There is no req/done overlap.
- mem_address is stable from cycle 1 until the end of RESP.

## Structure
- Package lsu_pkg holds:
  - the opcode localparams (OP_LB..OP_SW);
  - the state enum;
  - a function is_misaligned(opcode, addr[1:0]).
- One combinational sub-module, lsu_lane, holds the byte-lane logic:
  - inputs: word, addr[1:0], opcode, store_data;
  - outputs: extended load value and merged store word.
- The top level keeps the FSM and the registers.

## Test plan
- Memory word 0x10 = 0x8899AABB. lb addr 0x11: done in cycle 3, load_data=0xFFFFFF99, fault=0. lbu 0x11 returns 0x00000099.
- lh 0x12 on the same word returns 0xFFFFAABB. lhu 0x10 returns 0x00008899.
- sh addr 0x12, store_data 0x00001234: MemRead in cycle 1, MemWrite in cycle 3 with mem_writeData=0x88991234, done in cycle 4. A following lw 0x10 returns 0x88991234.
- lw addr 0x13: done=1 and fault=1 in cycle 1, load_data=0, MemRead/MemWrite never asserted. Opcode 000000 gives the same response.
- sw 0x10, 0xDEADBEEF, with rst high in cycle 1: mem_MemWrite stays 0, no done, ready=1 in cycle 2. A later lw 0x10 still returns 0x8899AABB.
- Two lw requests held back-to-back: second accepted in cycle 4 with done in cycle 7. req toggled while busy is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - opcodes, FSM states and alignment helpers for the load/store unit
package lsu_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return a != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_subword_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - big-endian byte/halfword lane extract, extend and merge
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [5:0]  opcode_i,
  input  logic [15:0] store_data_i,
  output logic [31:0] load_value_o,
  output logic [31:0] merged_word_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = word_i[31:24];
    case (addr_lo_i)
      2'd0: lane_byte = word_i[31:24];
      2'd1: lane_byte = word_i[23:16];
      2'd2: lane_byte = word_i[15:8];
      2'd3: lane_byte = word_i[7:0];
      default: lane_byte = word_i[31:24];
    endcase
    lane_half = addr_lo_i[1] ? word_i[15:0] : word_i[31:16];
  end

  always_comb begin
    load_value_o = word_i;
    case (opcode_i)
      OP_LB:   load_value_o = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_value_o = {24'd0, lane_byte};
      OP_LH:   load_value_o = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_value_o = {16'd0, lane_half};
      default: load_value_o = word_i;
    endcase
  end

  // Only the addressed lane is replaced; the rest comes from the word just read.
  always_comb begin
    merged_word_o = word_i;
    if (opcode_i == OP_SB) begin
      case (addr_lo_i)
        2'd0: merged_word_o = {store_data_i[7:0], word_i[23:0]};
        2'd1: merged_word_o = {word_i[31:24], store_data_i[7:0], word_i[15:0]};
        2'd2: merged_word_o = {word_i[31:16], store_data_i[7:0], word_i[7:0]};
        2'd3: merged_word_o = {word_i[31:8], store_data_i[7:0]};
        default: merged_word_o = word_i;
      endcase
    end else if (opcode_i == OP_SH) begin
      merged_word_o = addr_lo_i[1] ? {word_i[31:16], store_data_i}
                                   : {store_data_i, word_i[15:0]};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store FSM with read-modify-write sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              ready,
  output logic              done,
  output logic              fault,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [31:0]       mem_readData
);

  lsu_state_e        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [15:0]       sdata_q, sdata_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_q, load_d;
  logic              fault_q, fault_d;

  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  lsu_lane u_lane (
    .word_i        (mem_readData),
    .addr_lo_i     (addr_lo_q),
    .opcode_i      (op_q),
    .store_data_i  (sdata_q),
    .load_value_o  (lane_load),
    .merged_word_o (lane_merged)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_lo_d = addr_lo_q;
    sdata_d   = sdata_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    load_d    = load_q;
    fault_d   = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d      = opcode;
          addr_lo_d = addr[1:0];
          sdata_d   = store_data[15:0];
          maddr_d   = {addr[ADDR_W-1:2], 2'b00};
          fault_d   = 1'b0;
          if (!is_supported(opcode) || is_misaligned(opcode, addr[1:0])) begin
            fault_d = 1'b1;
            load_d  = 32'd0;
            state_d = ST_RESP;
          end else if (opcode == OP_SW) begin
            wdata_d = store_data;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (is_subword_store(op_q)) begin
          wdata_d = lane_merged;
          state_d = ST_WRITE;
        end else begin
          load_d  = lane_load;
          state_d = ST_RESP;
        end
      end
      ST_WRITE:   state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= 6'd0;
      addr_lo_q <= 2'd0;
      sdata_q   <= 16'd0;
      maddr_q   <= '0;
      wdata_q   <= 32'd0;
      load_q    <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_lo_q <= addr_lo_d;
      sdata_q   <= sdata_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      load_q    <= load_d;
      fault_q   <= fault_d;
    end
  end

  // Strobes and handshakes come straight from state so rst kills them in the same cycle.
  assign ready         = (state_q == ST_IDLE)  && !rst;
  assign done          = (state_q == ST_RESP)  && !rst;
  assign mem_MemRead   = (state_q == ST_READ)  && !rst;
  assign mem_MemWrite  = (state_q == ST_WRITE) && !rst;
  assign fault         = fault_q;
  assign load_data     = load_q;
  assign mem_address   = maddr_q;
  assign mem_writeData = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed checks of load_store_unit against a word memory model
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        ready, done, fault;
  logic [31:0] load_data, mem_address, mem_writeData, mem_readData;
  logic        mem_MemRead, mem_MemWrite;
  logic        mem_init;

  logic [31:0] mem [0:15];

  int n_cmp = 0;
  int n_bad = 0;

  int          done_cyc, done_cnt;
  logic [15:0] rd_mask, wr_mask, done_mask;
  logic [31:0] wd_seen, ld_seen, ld_seen2;
  logic        flt_seen, rdy_after;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .opcode        (opcode),
    .addr          (addr),
    .store_data    (store_data),
    .ready         (ready),
    .done          (done),
    .fault         (fault),
    .load_data     (load_data),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_MemRead   (mem_MemRead),
    .mem_MemWrite  (mem_MemWrite),
    .mem_readData  (mem_readData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h8899AABB;
      mem_readData <= 32'd0;
    end else begin
      if (mem_MemWrite) mem[mem_address[5:2]] <= mem_writeData;
      if (mem_MemRead)  mem_readData <= mem[mem_address[5:2]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  // Issue one request, scramble inputs after acceptance, then log 8 cycles.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd);
    wait_ready();
    req = 1'b1; opcode = op; addr = a; store_data = sd;
    @(posedge clk);
    #1;
    req = 1'b1; opcode = 6'b111111; addr = 32'hFFFF_FFFF; store_data = 32'h5A5A5A5A;
    done_cyc = -1; done_cnt = 0; rd_mask = '0; wr_mask = '0;
    wd_seen = 32'hDEAD0000; ld_seen = 32'hDEAD0000; flt_seen = 1'b0; rdy_after = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (mem_MemRead) rd_mask[c] = 1'b1;
      if (mem_MemWrite) begin
        wr_mask[c] = 1'b1;
        wd_seen = mem_writeData;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) rdy_after = ready;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          ld_seen  = load_data;
          flt_seen = fault;
        end
      end
    end
  endtask

  task automatic expect_op(input string tag, input int exp_done, input logic [15:0] exp_rd,
                           input logic [15:0] exp_wr, input logic [31:0] exp_wd,
                           input logic [31:0] exp_ld, input logic exp_flt);
    check_eq({tag, "/done_cyc"}, done_cyc, exp_done);
    check_eq({tag, "/done_cnt"}, done_cnt, 32'd1);
    check_eq({tag, "/rd_mask"}, {16'd0, rd_mask}, {16'd0, exp_rd});
    check_eq({tag, "/wr_mask"}, {16'd0, wr_mask}, {16'd0, exp_wr});
    if (exp_wr != 16'd0) check_eq({tag, "/wdata"}, wd_seen, exp_wd);
    if (exp_wr == 16'd0) check_eq({tag, "/load"}, ld_seen, exp_ld);
    check_eq({tag, "/fault"}, {31'd0, flt_seen}, {31'd0, exp_flt});
    check_eq({tag, "/ready_after"}, {31'd0, rdy_after}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; opcode = 6'd0; addr = 32'd0; store_data = 32'd0; mem_init = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst/ready", {31'd0, ready}, 32'd0);
    check_eq("rst/done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    check_eq("rst/ready_after", {31'd0, ready}, 32'd1);
    check_eq("rst/fault", {31'd0, fault}, 32'd0);
    check_eq("rst/load_data", load_data, 32'd0);
    check_eq("rst/strobes", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    check_eq("rst/mem_address", mem_address, 32'd0);
    check_eq("rst/mem_writeData", mem_writeData, 32'd0);

    run_op(OP_LB,  32'h11, 32'd0); expect_op("lb_11",  3, 16'h2, 16'h0, 32'd0, 32'hFFFFFF99, 1'b0);
    run_op(OP_LBU, 32'h11, 32'd0); expect_op("lbu_11", 3, 16'h2, 16'h0, 32'd0, 32'h00000099, 1'b0);
    run_op(OP_LH,  32'h12, 32'd0); expect_op("lh_12",  3, 16'h2, 16'h0, 32'd0, 32'hFFFFAABB, 1'b0);
    run_op(OP_LHU, 32'h10, 32'd0); expect_op("lhu_10", 3, 16'h2, 16'h0, 32'd0, 32'h00008899, 1'b0);

    // sw abandoned by rst in cycle 1
    wait_ready();
    req = 1'b1; opcode = OP_SW; addr = 32'h10; store_data = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("swrst/c1_write", {31'd0, mem_MemWrite}, 32'd0);
    check_eq("swrst/c1_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("swrst/c2_ready", {31'd0, ready}, 32'd1);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done || mem_MemWrite) done_cnt++;
      @(negedge clk);
    end
    check_eq("swrst/no_done_or_write", done_cnt, 32'd0);
    run_op(OP_LW, 32'h10, 32'd0); expect_op("swrst/lw_10", 3, 16'h2, 16'h0, 32'd0, 32'h8899AABB, 1'b0);

    run_op(OP_SH, 32'h12, 32'h00001234); expect_op("sh_12", 4, 16'h2, 16'h8, 32'h88991234, 32'd0, 1'b0);
    run_op(OP_LW, 32'h10, 32'd0);        expect_op("lw_after_sh", 3, 16'h2, 16'h0, 32'd0, 32'h88991234, 1'b0);
    run_op(OP_SB, 32'h13, 32'hABCDEF77); expect_op("sb_13", 4, 16'h2, 16'h8, 32'h88991277, 32'd0, 1'b0);
    run_op(OP_LB, 32'h13, 32'd0);        expect_op("lb_13", 3, 16'h2, 16'h0, 32'd0, 32'h00000077, 1'b0);
    run_op(OP_SW, 32'h14, 32'hCAFEF00D); expect_op("sw_14", 2, 16'h0, 16'h2, 32'hCAFEF00D, 32'd0, 1'b0);
    run_op(OP_LH, 32'h16, 32'd0);        expect_op("lh_16", 3, 16'h2, 16'h0, 32'd0, 32'hFFFFF00D, 1'b0);
    run_op(OP_LB, 32'h14, 32'd0);        expect_op("lb_14", 3, 16'h2, 16'h0, 32'd0, 32'hFFFFFFCA, 1'b0);

    run_op(OP_LW, 32'h13, 32'd0);        expect_op("flt_lw_13", 1, 16'h0, 16'h0, 32'd0, 32'd0, 1'b1);
    run_op(6'b000000, 32'h10, 32'd0);    expect_op("flt_op0", 1, 16'h0, 16'h0, 32'd0, 32'd0, 1'b1);
    run_op(OP_SH, 32'h11, 32'h0000FFFF); expect_op("flt_sh_11", 1, 16'h0, 16'h0, 32'd0, 32'd0, 1'b1);
    run_op(OP_SW, 32'h12, 32'h11111111); expect_op("flt_sw_12", 1, 16'h0, 16'h0, 32'd0, 32'd0, 1'b1);
    run_op(OP_LW, 32'h10, 32'd0);        expect_op("lw_after_faults", 3, 16'h2, 16'h0, 32'd0, 32'h88991277, 1'b0);

    // two lw held back-to-back, with req/addr churn while busy
    wait_ready();
    req = 1'b1; opcode = OP_LW; addr = 32'h10; store_data = 32'd0;
    @(posedge clk);
    #1;
    rd_mask = '0; wr_mask = '0; done_mask = '0; ld_seen = 32'hDEAD0000; ld_seen2 = 32'hDEAD0000;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (mem_MemRead)  rd_mask[c] = 1'b1;
      if (mem_MemWrite) wr_mask[c] = 1'b1;
      if (done) begin
        done_mask[c] = 1'b1;
        if (c == 3) ld_seen = load_data;
        if (c == 7) ld_seen2 = load_data;
      end
      if (c < 4) begin
        req = c[0]; opcode = OP_SW; addr = 32'h13;
      end else if (c == 4) begin
        req = 1'b1; opcode = OP_LW; addr = 32'h10;
      end else begin
        req = 1'b0;
      end
    end
    check_eq("b2b/done_mask", {16'd0, done_mask}, 32'h88);
    check_eq("b2b/rd_mask", {16'd0, rd_mask}, 32'h22);
    check_eq("b2b/wr_mask", {16'd0, wr_mask}, 32'h0);
    check_eq("b2b/load1", ld_seen, 32'h88991277);
    check_eq("b2b/load2", ld_seen2, 32'h88991277);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
